mul_err_sweep: RTL

MUL_ERR_SWEEP -- requirements
Module: mul_err_sweep

---
 rtl/mul_err_sweep_pkg.sv | 32 +++
 rtl/mul_err_acc.sv | 104 ++++++++++
 rtl/mul_err_sweep.sv | 112 +++++++++++
 3 files changed

// File: rtl/mul_err_sweep_pkg.sv
// Shared definitions for the approximate-multiplier error sweep: the sweep
// FSM state type, default operand/product widths and the derived widths of
// the pair index and the statistics accumulators.
package mul_err_sweep_pkg;

    localparam int AW_DEF = 6;
    localparam int BW_DEF = 6;
    localparam int PW_DEF = AW_DEF + BW_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Pair index {A,B}; one bit per operand bit.
    function automatic int idx_w(input int aw, input int bw);
        return aw + bw;
    endfunction

    // Error counter must hold 2^(AW+BW) itself, hence one extra bit.
    function automatic int cnt_w(input int aw, input int bw);
        return aw + bw + 1;
    endfunction

    // Sum of up to 2^(AW+BW) errors, each below 2^PW.
    function automatic int sum_w(input int pw, input int aw, input int bw);
        return pw + aw + bw;
    endfunction

endpackage

// File: rtl/mul_err_acc.sv
// Compare/accumulate datapath: stage 1 registers the absolute error of the
// current pair, the following edge folds it into the running statistics.
module mul_err_acc
    import mul_err_sweep_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int BW = BW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AW-1:0]                 i_a,
    input  logic [BW-1:0]                 i_b,
    input  logic [PW-1:0]                 i_p,
    input  logic                          i_vld,
    input  logic                          i_flush,
    input  logic                          i_clear,
    output logic [cnt_w(AW, BW)-1:0]      o_err_cnt,
    output logic [PW-1:0]                 o_max_err,
    output logic [sum_w(PW, AW, BW)-1:0]  o_sum_err,
    output logic [AW-1:0]                 o_first_a,
    output logic [BW-1:0]                 o_first_b,
    output logic                          o_first_vld
);

    localparam int CW = cnt_w(AW, BW);
    localparam int SW = sum_w(PW, AW, BW);

    logic [PW-1:0]        w_exact;
    logic signed [PW:0]   w_diff;
    logic [PW-1:0]        w_abs;

    logic                 r_s1_vld;
    logic [PW-1:0]        r_s1_err;
    logic [AW-1:0]        r_s1_a;
    logic [BW-1:0]        r_s1_b;

    logic [CW-1:0]        r_err_cnt;
    logic [PW-1:0]        r_max_err;
    logic [SW-1:0]        r_sum_err;
    logic [AW-1:0]        r_first_a;
    logic [BW-1:0]        r_first_b;
    logic                 r_first_vld;

    // Exact reference product and the magnitude of the signed difference.
    assign w_exact = PW'(i_a) * PW'(i_b);
    assign w_diff  = $signed({1'b0, i_p}) - $signed({1'b0, w_exact});
    assign w_abs   = w_diff[PW] ? PW'(-w_diff) : w_diff[PW-1:0];

    // Stage 1: capture the error of the pair presented this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_err <= '0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
        end else begin
            r_s1_vld <= i_vld && !i_flush;
            r_s1_err <= w_abs;
            r_s1_a   <= i_a;
            r_s1_b   <= i_b;
        end
    end

    // Statistics: cleared on an accepted start, updated from a live stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt   <= '0;
            r_max_err   <= '0;
            r_sum_err   <= '0;
            r_first_a   <= '0;
            r_first_b   <= '0;
            r_first_vld <= 1'b0;
        end else if (i_clear) begin
            r_err_cnt   <= '0;
            r_max_err   <= '0;
            r_sum_err   <= '0;
            r_first_a   <= '0;
            r_first_b   <= '0;
            r_first_vld <= 1'b0;
        end else if (r_s1_vld && !i_flush) begin
            r_err_cnt <= r_err_cnt + CW'(r_s1_err != '0);
            r_sum_err <= r_sum_err + SW'(r_s1_err);
            if (r_s1_err > r_max_err) begin
                r_max_err <= r_s1_err;
            end
            if (r_s1_err != '0 && !r_first_vld) begin
                r_first_a   <= r_s1_a;
                r_first_b   <= r_s1_b;
                r_first_vld <= 1'b1;
            end
        end
    end

    assign o_err_cnt   = r_err_cnt;
    assign o_max_err   = r_max_err;
    assign o_sum_err   = r_sum_err;
    assign o_first_a   = r_first_a;
    assign o_first_b   = r_first_b;
    assign o_first_vld = r_first_vld;

endmodule

// File: rtl/mul_err_sweep.sv
// Exhaustive error sweep of an external approximate multiplier: walks every
// {A,B} operand pair once, in ascending order, and gathers error statistics.
module mul_err_sweep
    import mul_err_sweep_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int BW = BW_DEF,
    parameter int PW = AW + BW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [AW-1:0]                 mul_a,
    output logic [BW-1:0]                 mul_b,
    input  logic [PW-1:0]                 mul_p,
    output logic [cnt_w(AW, BW)-1:0]      err_cnt,
    output logic [PW-1:0]                 max_err,
    output logic [sum_w(PW, AW, BW)-1:0]  sum_err,
    output logic [AW-1:0]                 first_a,
    output logic [BW-1:0]                 first_b,
    output logic                          first_vld
);

    localparam int IW = idx_w(AW, BW);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic            r_busy;
    logic            r_done;

    logic            w_start_acc;
    logic            w_abort;
    logic            w_last;
    logic            w_s1_load;

    assign w_start_acc = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_abort     = abort && (r_state == ST_RUN || r_state == ST_DRAIN);
    assign w_last      = &r_idx;
    // Only RUN presents new pairs; DRAIN merely lets stage 1 retire.
    assign w_s1_load   = (r_state == ST_RUN) && !w_abort;

    // Next-state decode; abort has priority over every other transition.
    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch
        // is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_acc) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_abort)     w_state_nxt = ST_IDLE;
                      else if (w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_abort)     w_state_nxt = ST_IDLE;
                      else             w_state_nxt = ST_DONE;
            ST_DONE:  if (w_start_acc) w_state_nxt = ST_RUN;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus registered busy/done flags decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Pair index: loaded with 0 on start, steps once per RUN cycle, no wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_start_acc) begin
            r_idx <= '0;
        end else if (w_s1_load && !w_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign mul_a = r_idx[IW-1:BW];
    assign mul_b = r_idx[BW-1:0];
    assign busy  = r_busy;
    assign done  = r_done;

    mul_err_acc #(
        .AW (AW),
        .BW (BW),
        .PW (PW)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_a         (mul_a),
        .i_b         (mul_b),
        .i_p         (mul_p),
        .i_vld       (w_s1_load),
        .i_flush     (w_abort),
        .i_clear     (w_start_acc),
        .o_err_cnt   (err_cnt),
        .o_max_err   (max_err),
        .o_sum_err   (sum_err),
        .o_first_a   (first_a),
        .o_first_b   (first_b),
        .o_first_vld (first_vld)
    );

endmodule
